reservation_station: RTL and testbench

Out-of-order issue buffer for integer ALU instructions: it receives instructions the decoder dispatches, holds them until both source operands are known, and sends one ready instruction per cycle to the ALU. It sits between the decoder's RS dispatch port and the ALU. It listens to the ALU and load/store result broadcast buses (CDB) to resolve pending ROB-tag dependencies, and it drops all state on a branch-mispredict clear.

---
 rtl/reservation_station.sv | 180 ++++++++++++++++++
 tb/tb_reservation_station.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Integer ALU reservation station: buffers dispatched ops, wakes them from the ALU/LSB
// result buses and issues the lowest-index ready entry each cycle.
module reservation_station #(
  parameter int RS_SIZE = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _rs_ready,
  input  logic [4:0]  _rs_type,
  input  logic [4:0]  _rs_rob_id,
  input  logic [31:0] _rs_r1,
  input  logic [31:0] _rs_r2,
  input  logic [31:0] _rs_imm,
  input  logic        _rs_has_dep1,
  input  logic        _rs_has_dep2,
  input  logic [4:0]  _rs_dep1,
  input  logic [4:0]  _rs_dep2,
  output logic        _rs_full,
  input  logic        _cdb_alu_valid,
  input  logic [4:0]  _cdb_alu_rob_id,
  input  logic [31:0] _cdb_alu_value,
  input  logic        _cdb_lsb_valid,
  input  logic [4:0]  _cdb_lsb_rob_id,
  input  logic [31:0] _cdb_lsb_value,
  output logic        _alu_ready,
  output logic [4:0]  _alu_type,
  output logic [4:0]  _alu_rob_id,
  output logic [31:0] _alu_v1,
  output logic [31:0] _alu_v2,
  output logic [31:0] _alu_imm
);
  // Handshake: a dispatch is taken on an edge with rdy_in=1, _rs_ready=1 and _rs_full=0;
  // _alu_ready is a one-cycle valid pulse with no ready/backpressure from the ALU.
  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic        busy;
    logic [4:0]  op;
    logic [4:0]  rob_id;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic        q1_valid;
    logic [4:0]  q1;
    logic        q2_valid;
    logic [4:0]  q2;
  } entry_t;

  entry_t ent_q [RS_SIZE];
  entry_t ent_d [RS_SIZE];
  entry_t new_e;

  logic        alu_ready_q, alu_ready_d;
  logic [4:0]  alu_type_q, alu_type_d;
  logic [4:0]  alu_rob_q, alu_rob_d;
  logic [31:0] alu_v1_q, alu_v1_d;
  logic [31:0] alu_v2_q, alu_v2_d;
  logic [31:0] alu_imm_q, alu_imm_d;

  logic [RS_SIZE-1:0] busy_vec;
  logic               sel_found;
  logic [IW-1:0]      sel_idx;
  logic [IW-1:0]      free_idx;

  // Returns {still_pending, value}; the ALU bus wins when both buses carry the tag.
  function automatic logic [32:0] resolve(
    input logic        pending,
    input logic [4:0]  tag,
    input logic [31:0] cur,
    input logic        a_vld,
    input logic [4:0]  a_tag,
    input logic [31:0] a_val,
    input logic        l_vld,
    input logic [4:0]  l_tag,
    input logic [31:0] l_val
  );
    if (!pending)                  return {1'b0, cur};
    if (a_vld && (a_tag == tag))   return {1'b0, a_val};
    if (l_vld && (l_tag == tag))   return {1'b0, l_val};
    return {1'b1, cur};
  endfunction

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    busy_vec  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      busy_vec[i] = ent_q[i].busy;
      if (ent_q[i].busy && !ent_q[i].q1_valid && !ent_q[i].q2_valid) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
      if (!ent_q[i].busy) free_idx = IW'(i);
    end
  end

  assign _rs_full = &busy_vec;

  always_comb begin
    new_e        = '0;
    new_e.busy   = 1'b1;
    new_e.op     = _rs_type;
    new_e.rob_id = _rs_rob_id;
    new_e.imm    = _rs_imm;
    new_e.q1     = _rs_dep1;
    new_e.q2     = _rs_dep2;
    {new_e.q1_valid, new_e.v1} = resolve(_rs_has_dep1, _rs_dep1, _rs_r1,
      _cdb_alu_valid, _cdb_alu_rob_id, _cdb_alu_value,
      _cdb_lsb_valid, _cdb_lsb_rob_id, _cdb_lsb_value);
    {new_e.q2_valid, new_e.v2} = resolve(_rs_has_dep2, _rs_dep2, _rs_r2,
      _cdb_alu_valid, _cdb_alu_rob_id, _cdb_alu_value,
      _cdb_lsb_valid, _cdb_lsb_rob_id, _cdb_lsb_value);
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) ent_d[i] = ent_q[i];
    alu_ready_d = 1'b0;
    alu_type_d  = alu_type_q;
    alu_rob_d   = alu_rob_q;
    alu_v1_d    = alu_v1_q;
    alu_v2_d    = alu_v2_q;
    alu_imm_d   = alu_imm_q;
    if (_clear) begin
      for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent_q[i].busy) begin
          {ent_d[i].q1_valid, ent_d[i].v1} = resolve(ent_q[i].q1_valid, ent_q[i].q1, ent_q[i].v1,
            _cdb_alu_valid, _cdb_alu_rob_id, _cdb_alu_value,
            _cdb_lsb_valid, _cdb_lsb_rob_id, _cdb_lsb_value);
          {ent_d[i].q2_valid, ent_d[i].v2} = resolve(ent_q[i].q2_valid, ent_q[i].q2, ent_q[i].v2,
            _cdb_alu_valid, _cdb_alu_rob_id, _cdb_alu_value,
            _cdb_lsb_valid, _cdb_lsb_rob_id, _cdb_lsb_value);
        end
      end
      if (sel_found) begin
        ent_d[sel_idx].busy = 1'b0;
        alu_ready_d = 1'b1;
        alu_type_d  = ent_q[sel_idx].op;
        alu_rob_d   = ent_q[sel_idx].rob_id;
        alu_v1_d    = ent_q[sel_idx].v1;
        alu_v2_d    = ent_q[sel_idx].v2;
        alu_imm_d   = ent_q[sel_idx].imm;
      end
      // Free slot comes from start-of-cycle busy bits, so it never collides with the issued slot.
      if (_rs_ready && !_rs_full) ent_d[free_idx] = new_e;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      alu_ready_q <= 1'b0;
      alu_type_q  <= '0;
      alu_rob_q   <= '0;
      alu_v1_q    <= '0;
      alu_v2_q    <= '0;
      alu_imm_q   <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
      alu_ready_q <= alu_ready_d;
      alu_type_q  <= alu_type_d;
      alu_rob_q   <= alu_rob_d;
      alu_v1_q    <= alu_v1_d;
      alu_v2_q    <= alu_v2_d;
      alu_imm_q   <= alu_imm_d;
    end
  end

  assign _alu_ready  = alu_ready_q;
  assign _alu_type   = alu_type_q;
  assign _alu_rob_id = alu_rob_q;
  assign _alu_v1     = alu_v1_q;
  assign _alu_v2     = alu_v2_q;
  assign _alu_imm    = alu_imm_q;

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios then random traffic, all checked
// against a slot-level behavioural model of the station.
module tb_reservation_station;
  localparam int N  = 8;
  localparam int PW = 106;
  localparam logic [4:0] ADD = 5'h01;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, _clear, _rs_ready;
  logic [4:0]  _rs_type, _rs_rob_id, _rs_dep1, _rs_dep2;
  logic [31:0] _rs_r1, _rs_r2, _rs_imm;
  logic        _rs_has_dep1, _rs_has_dep2;
  logic        _rs_full;
  logic        _cdb_alu_valid, _cdb_lsb_valid;
  logic [4:0]  _cdb_alu_rob_id, _cdb_lsb_rob_id;
  logic [31:0] _cdb_alu_value, _cdb_lsb_value;
  logic        _alu_ready;
  logic [4:0]  _alu_type, _alu_rob_id;
  logic [31:0] _alu_v1, _alu_v2, _alu_imm;

  always #5 clk_in = ~clk_in;

  reservation_station #(.RS_SIZE(N)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
    ._rs_ready(_rs_ready), ._rs_type(_rs_type), ._rs_rob_id(_rs_rob_id),
    ._rs_r1(_rs_r1), ._rs_r2(_rs_r2), ._rs_imm(_rs_imm),
    ._rs_has_dep1(_rs_has_dep1), ._rs_has_dep2(_rs_has_dep2),
    ._rs_dep1(_rs_dep1), ._rs_dep2(_rs_dep2), ._rs_full(_rs_full),
    ._cdb_alu_valid(_cdb_alu_valid), ._cdb_alu_rob_id(_cdb_alu_rob_id), ._cdb_alu_value(_cdb_alu_value),
    ._cdb_lsb_valid(_cdb_lsb_valid), ._cdb_lsb_rob_id(_cdb_lsb_rob_id), ._cdb_lsb_value(_cdb_lsb_value),
    ._alu_ready(_alu_ready), ._alu_type(_alu_type), ._alu_rob_id(_alu_rob_id),
    ._alu_v1(_alu_v1), ._alu_v2(_alu_v2), ._alu_imm(_alu_imm)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          busy;
    logic [4:0]  op, rob;
    logic [31:0] v1, v2, imm;
    bit          p1, p2;
    logic [4:0]  t1, t2;
  } m_ent_t;

  m_ent_t         m [N];
  bit             e_ready;
  logic [PW-1:0]  e_pkt;
  logic [PW-1:0]  exp_q [$];

  function automatic logic [32:0] resolve(input bit p, input logic [4:0] t, input logic [31:0] v);
    if (!p) return {1'b0, v};
    if (_cdb_alu_valid && _cdb_alu_rob_id == t) return {1'b0, _cdb_alu_value};
    if (_cdb_lsb_valid && _cdb_lsb_rob_id == t) return {1'b0, _cdb_lsb_value};
    return {1'b1, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i] = '{default: '0};
    e_ready = 1'b0;
    e_pkt   = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    m_ent_t nxt [N];
    int iss, fr;
    if (!rdy_in) return;
    if (_clear) begin
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      e_ready = 1'b0;
      return;
    end
    iss = -1;
    fr  = -1;
    for (int i = 0; i < N; i++) begin
      nxt[i] = m[i];
      if (iss < 0 && m[i].busy && !m[i].p1 && !m[i].p2) iss = i;
      if (fr < 0 && !m[i].busy) fr = i;
      if (m[i].busy) begin
        {nxt[i].p1, nxt[i].v1} = resolve(m[i].p1, m[i].t1, m[i].v1);
        {nxt[i].p2, nxt[i].v2} = resolve(m[i].p2, m[i].t2, m[i].v2);
      end
    end
    e_ready = (iss >= 0);
    if (iss >= 0) begin
      e_pkt = {m[iss].op, m[iss].rob, m[iss].v1, m[iss].v2, m[iss].imm};
      exp_q.push_back(e_pkt);
      nxt[iss].busy = 1'b0;
    end
    if (_rs_ready && fr >= 0) begin
      nxt[fr].busy = 1'b1;
      nxt[fr].op   = _rs_type;
      nxt[fr].rob  = _rs_rob_id;
      nxt[fr].imm  = _rs_imm;
      nxt[fr].t1   = _rs_dep1;
      nxt[fr].t2   = _rs_dep2;
      {nxt[fr].p1, nxt[fr].v1} = resolve(_rs_has_dep1, _rs_dep1, _rs_r1);
      {nxt[fr].p2, nxt[fr].v2} = resolve(_rs_has_dep2, _rs_dep2, _rs_r2);
    end
    for (int i = 0; i < N; i++) m[i] = nxt[i];
  endtask

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] dut_pkt();
    return {_alu_type, _alu_rob_id, _alu_v1, _alu_v2, _alu_imm};
  endfunction

  task automatic check_outputs();
    bit all_busy;
    all_busy = 1'b1;
    for (int i = 0; i < N; i++) all_busy &= m[i].busy;
    chk("rs_full", PW'(_rs_full), PW'(all_busy));
    chk("alu_ready", PW'(_alu_ready), PW'(e_ready));
    if (e_ready && exp_q.size() > 0) chk("issue_pkt", dut_pkt(), exp_q.pop_front());
    else chk("held_pkt", dut_pkt(), e_pkt);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    rdy_in = 1'b1; _clear = 1'b0; _rs_ready = 1'b0;
    _rs_has_dep1 = 1'b0; _rs_has_dep2 = 1'b0;
    _cdb_alu_valid = 1'b0; _cdb_lsb_valid = 1'b0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [4:0] rob, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [31:0] imm, input bit hd1,
                      input logic [4:0] d1, input bit hd2, input logic [4:0] d2);
    _rs_ready = 1'b1; _rs_type = op; _rs_rob_id = rob;
    _rs_r1 = r1; _rs_r2 = r2; _rs_imm = imm;
    _rs_has_dep1 = hd1; _rs_dep1 = d1; _rs_has_dep2 = hd2; _rs_dep2 = d2;
  endtask

  task automatic cdb_alu(input logic [4:0] tag, input logic [31:0] val);
    _cdb_alu_valid = 1'b1; _cdb_alu_rob_id = tag; _cdb_alu_value = val;
  endtask

  task automatic cdb_lsb(input logic [4:0] tag, input logic [31:0] val);
    _cdb_lsb_valid = 1'b1; _cdb_lsb_rob_id = tag; _cdb_lsb_value = val;
  endtask

  task automatic expect_issue(input string tag, input logic [4:0] rob, input logic [31:0] v1,
                              input logic [31:0] v2);
    chk({tag, "_ready"}, PW'(_alu_ready), PW'(1'b1));
    chk({tag, "_rob"}, PW'(_alu_rob_id), PW'(rob));
    chk({tag, "_v1"}, PW'(_alu_v1), PW'(v1));
    chk({tag, "_v2"}, PW'(_alu_v2), PW'(v2));
  endtask

  initial begin
    idle();
    _rs_type = '0; _rs_rob_id = '0; _rs_r1 = '0; _rs_r2 = '0; _rs_imm = '0;
    _rs_dep1 = '0; _rs_dep2 = '0;
    _cdb_alu_rob_id = '0; _cdb_alu_value = '0; _cdb_lsb_rob_id = '0; _cdb_lsb_value = '0;
    rst_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_outputs();
    chk("reset_pkt", dut_pkt(), PW'(0));
    rst_in = 1'b1;

    // Three back-to-back dependency-free dispatches.
    disp(ADD, 5'd1, 32'd5, 32'd7, 32'd0, 0, 5'd0, 0, 5'd0); cycle();
    chk("a_no_early", PW'(_alu_ready), PW'(1'b0));
    disp(ADD, 5'd2, 32'd5, 32'd7, 32'd0, 0, 5'd0, 0, 5'd0); cycle();
    expect_issue("a1", 5'd1, 32'd5, 32'd7);
    disp(ADD, 5'd3, 32'd5, 32'd7, 32'd0, 0, 5'd0, 0, 5'd0); cycle();
    expect_issue("a2", 5'd2, 32'd5, 32'd7);
    idle(); cycle();
    expect_issue("a3", 5'd3, 32'd5, 32'd7);
    cycle();
    chk("a_idle", PW'(_alu_ready), PW'(1'b0));

    // Dependency resolved by a later ALU broadcast.
    disp(ADD, 5'd4, 32'd0, 32'd7, 32'd0, 1, 5'd2, 0, 5'd0); cycle();
    idle();
    repeat (3) begin cycle(); chk("b_wait", PW'(_alu_ready), PW'(1'b0)); end
    cdb_alu(5'd2, 32'h100); cycle();
    chk("b_bcast_edge", PW'(_alu_ready), PW'(1'b0));
    idle(); cycle();
    expect_issue("b", 5'd4, 32'h100, 32'd7);
    cycle();

    // Same-cycle bypass from the LSB bus at dispatch.
    disp(ADD, 5'd5, 32'd1, 32'd0, 32'd0, 0, 5'd0, 1, 5'd9);
    cdb_lsb(5'd9, 32'hDEAD); cycle();
    chk("c_edge1", PW'(_alu_ready), PW'(1'b0));
    idle(); cycle();
    expect_issue("c", 5'd5, 32'd1, 32'hDEAD);
    cycle();

    // Fill every entry with a pending dependency, then overflow.
    for (int i = 0; i < N; i++) begin
      disp(ADD, 5'(10 + i), 32'd0, 32'(i), 32'(i), 1, 5'(10 + i), 0, 5'd0); cycle();
    end
    chk("d_full", PW'(_rs_full), PW'(1'b1));
    disp(ADD, 5'd20, 32'd1, 32'd2, 32'd3, 0, 5'd0, 0, 5'd0); cycle();
    chk("d_drop_full", PW'(_rs_full), PW'(1'b1));
    chk("d_drop_noissue", PW'(_alu_ready), PW'(1'b0));
    idle(); cdb_lsb(5'd13, 32'h1313); cycle();
    chk("d_bcast_full", PW'(_rs_full), PW'(1'b1));
    idle(); cycle();
    expect_issue("d13", 5'd13, 32'h1313, 32'd3);
    chk("d_full_fall", PW'(_rs_full), PW'(1'b0));
    cdb_alu(5'd10, 32'hA1A1); cdb_lsb(5'd10, 32'hB2B2); cycle();
    idle(); cycle();
    expect_issue("d_prio", 5'd10, 32'hA1A1, 32'd0);
    for (int t = 11; t < 18; t++) begin
      if (t != 13) begin idle(); cdb_alu(5'(t), $urandom); cycle(); end
    end
    idle(); repeat (3) cycle();

    // Flush with a ready entry, a dispatch and a broadcast all in the flush cycle.
    for (int i = 0; i < 4; i++) begin
      disp(ADD, 5'(21 + i), 32'd0, 32'd1, 32'd0, 1, 5'(21 + i), 0, 5'd0); cycle();
    end
    disp(ADD, 5'd25, 32'd2, 32'd3, 32'd0, 0, 5'd0, 0, 5'd0); cycle();
    disp(ADD, 5'd26, 32'd4, 32'd5, 32'd0, 0, 5'd0, 0, 5'd0);
    cdb_alu(5'd21, 32'h2121); _clear = 1'b1; cycle();
    chk("e_clear_ready", PW'(_alu_ready), PW'(1'b0));
    chk("e_clear_full", PW'(_rs_full), PW'(1'b0));
    for (int t = 21; t < 26; t++) begin
      idle(); cdb_alu(5'(t), 32'(t)); cycle();
      chk("e_stale", PW'(_alu_ready), PW'(1'b0));
    end
    idle(); cycle();

    // Stall with a valid issue on the outputs and an active broadcast.
    disp(ADD, 5'd27, 32'h11, 32'h22, 32'h33, 0, 5'd0, 0, 5'd0); cycle();
    disp(ADD, 5'd28, 32'd0, 32'h44, 32'h55, 1, 5'd30, 0, 5'd0); cycle();
    expect_issue("f_pre", 5'd27, 32'h11, 32'h22);
    rdy_in = 1'b0;
    disp(ADD, 5'd29, 32'd9, 32'd9, 32'd9, 0, 5'd0, 0, 5'd0);
    cdb_alu(5'd30, 32'h3030);
    repeat (4) begin cycle(); expect_issue("f_hold", 5'd27, 32'h11, 32'h22); end
    idle(); cycle();
    chk("f_ignored", PW'(_alu_ready), PW'(1'b0));
    cycle();
    chk("f_ignored2", PW'(_alu_ready), PW'(1'b0));
    cdb_alu(5'd30, 32'h3030); cycle();
    idle(); cycle();
    expect_issue("f_wake", 5'd28, 32'h3030, 32'h44);

    // Asynchronous reset between clock edges.
    #2 rst_in = 1'b0;
    #1;
    chk("g_rst_ready", PW'(_alu_ready), PW'(1'b0));
    chk("g_rst_pkt", dut_pkt(), PW'(0));
    chk("g_rst_full", PW'(_rs_full), PW'(1'b0));
    model_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    check_outputs();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      rdy_in         = ($urandom_range(0, 9) != 0);
      _clear         = ($urandom_range(0, 39) == 0);
      _rs_ready      = ($urandom_range(0, 2) != 0);
      _rs_type       = 5'($urandom_range(0, 31));
      _rs_rob_id     = 5'($urandom_range(0, 31));
      _rs_r1         = $urandom;
      _rs_r2         = $urandom;
      _rs_imm        = $urandom;
      _rs_has_dep1   = ($urandom_range(0, 1) != 0);
      _rs_has_dep2   = ($urandom_range(0, 2) == 0);
      _rs_dep1       = 5'($urandom_range(0, 7));
      _rs_dep2       = 5'($urandom_range(0, 7));
      _cdb_alu_valid = ($urandom_range(0, 1) != 0);
      _cdb_alu_rob_id = 5'($urandom_range(0, 7));
      _cdb_alu_value = $urandom;
      _cdb_lsb_valid = ($urandom_range(0, 1) != 0);
      _cdb_lsb_rob_id = 5'($urandom_range(0, 7));
      _cdb_lsb_value = $urandom;
      cycle();
    end
    idle(); repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
